program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 71 +++++++
 tb/tb_program_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Registered program counter with increment, previous-value and change tracking.
// Optional registered even-parity output enabled by defining PC_PARITY_EN.
module program_counter #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] pc_plus1,
    output logic [WIDTH-1:0] prev_out,
    output logic             changed,
    output logic             at_max,
    output logic             parity
);

    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] data_q,    data_d;
    logic [WIDTH-1:0] prev_q,    prev_d;
    logic             changed_q, changed_d;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        data_d    = data_in;
        prev_d    = data_q;
        changed_d = (data_in != data_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample old values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= RESET_V;
            prev_q    <= RESET_V;
            changed_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            prev_q    <= prev_d;
            changed_q <= changed_d;
        end
    end

    assign data_out = data_q;
    assign prev_out = prev_q;
    assign changed  = changed_q;
    assign pc_plus1 = data_q + WIDTH'(1);
    assign at_max   = &data_q;

`ifdef PC_PARITY_EN
    logic parity_q, parity_d;

    // Parity of data_in is captured with the load, so it always matches data_out.
    always_comb begin
        parity_d = ^data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= ^RESET_V;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (default WIDTH=4, RESET_VAL=0).
// Parity expectations follow whether PC_PARITY_EN is defined for the build.
module tb_program_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] prev_out;
    logic             changed;
    logic             at_max;
    logic             parity;

    int checks;
    int errors;

    program_counter #(.WIDTH(WIDTH), .RESET_VAL(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .pc_plus1 (pc_plus1),
        .prev_out (prev_out),
        .changed  (changed),
        .at_max   (at_max),
        .parity   (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Drive a new value at the falling edge, then sample 1 ns after the rising edge.
    task automatic load(input logic [WIDTH-1:0] val);
        @(negedge clk);
        data_in = val;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        data_in = '0;
        reset   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 4'd0) begin errors++; $display("FAIL reset_data_out got %0h required 0", data_out); end
        checks++;
        if (prev_out !== 4'd0) begin errors++; $display("FAIL reset_prev_out got %0h required 0", prev_out); end
        checks++;
        if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b required 0", changed); end
        checks++;
        if (pc_plus1 !== 4'd1) begin errors++; $display("FAIL reset_pc_plus1 got %0h required 1", pc_plus1); end
        checks++;
        if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got %b required 0", at_max); end
        checks++;
        if (parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b required 0", parity); end
        reset = 1'b1;
    endtask

    task automatic test_load_sweep;
        logic [WIDTH-1:0] old;
        old = 4'd0;
        for (int i = 0; i < 16; i++) begin
            load(WIDTH'(i));
            checks++;
            if (data_out !== WIDTH'(i)) begin errors++; $display("FAIL sweep_data_out[%0d] got %0h required %0h", i, data_out, i); end
            checks++;
            if (prev_out !== old) begin errors++; $display("FAIL sweep_prev_out[%0d] got %0h required %0h", i, prev_out, old); end
            checks++;
            if (changed !== (WIDTH'(i) != old)) begin errors++; $display("FAIL sweep_changed_step[%0d] got %b required %b", i, changed, WIDTH'(i) != old); end
            checks++;
            if (pc_plus1 !== WIDTH'(i + 1)) begin errors++; $display("FAIL sweep_pc_plus1[%0d] got %0h required %0h", i, pc_plus1, WIDTH'(i + 1)); end
            checks++;
            if (at_max !== (i == 15)) begin errors++; $display("FAIL sweep_at_max[%0d] got %b required %b", i, at_max, i == 15); end
            // Second edge of the 20 ns step: same data, so no change.
            @(posedge clk);
            #1;
            checks++;
            if (changed !== 1'b0) begin errors++; $display("FAIL sweep_changed_hold[%0d] got %b required 0", i, changed); end
            checks++;
            if (prev_out !== WIDTH'(i)) begin errors++; $display("FAIL sweep_prev_hold[%0d] got %0h required %0h", i, prev_out, i); end
            old = WIDTH'(i);
        end
    endtask

    task automatic test_wrap;
        load(4'hF);
        checks++;
        if (at_max !== 1'b1) begin errors++; $display("FAIL wrap_at_max got %b required 1", at_max); end
        checks++;
        if (pc_plus1 !== 4'd0) begin errors++; $display("FAIL wrap_pc_plus1 got %0h required 0", pc_plus1); end
        load(4'h0);
        checks++;
        if (data_out !== 4'd0) begin errors++; $display("FAIL wrap_data_out got %0h required 0", data_out); end
        checks++;
        if (prev_out !== 4'hF) begin errors++; $display("FAIL wrap_prev_out got %0h required f", prev_out); end
        checks++;
        if (at_max !== 1'b0) begin errors++; $display("FAIL wrap_at_max_clear got %b required 0", at_max); end
        checks++;
        if (changed !== 1'b1) begin errors++; $display("FAIL wrap_changed got %b required 1", changed); end
    endtask

    task automatic test_hold_between_edges;
        load(4'h3);
        @(negedge clk);
        data_in = 4'hA;
        #1;
        data_in = 4'h6;
        #1;
        checks++;
        if (data_out !== 4'h3) begin errors++; $display("FAIL hold_data_out got %0h required 3", data_out); end
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 4'h6) begin errors++; $display("FAIL hold_next_edge got %0h required 6", data_out); end
        checks++;
        if (prev_out !== 4'h3) begin errors++; $display("FAIL hold_prev_out got %0h required 3", prev_out); end
    endtask

    task automatic test_mid_run_reset;
        load(4'h9);
        checks++;
        if (data_out !== 4'h9) begin errors++; $display("FAIL midrst_preload got %0h required 9", data_out); end
        @(negedge clk);
        data_in = 4'h5;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 4'd0) begin errors++; $display("FAIL midrst_data_out got %0h required 0", data_out); end
        checks++;
        if (prev_out !== 4'd0) begin errors++; $display("FAIL midrst_prev_out got %0h required 0", prev_out); end
        checks++;
        if (changed !== 1'b0) begin errors++; $display("FAIL midrst_changed got %b required 0", changed); end
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 4'd0) begin errors++; $display("FAIL midrst_edge_ignored got %0h required 0", data_out); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 4'h5) begin errors++; $display("FAIL midrst_first_load got %0h required 5", data_out); end
        checks++;
        if (prev_out !== 4'd0) begin errors++; $display("FAIL midrst_first_prev got %0h required 0", prev_out); end
        checks++;
        if (changed !== 1'b1) begin errors++; $display("FAIL midrst_first_changed got %b required 1", changed); end
    endtask

    task automatic test_parity;
`ifdef PC_PARITY_EN
        load(4'b0111);
        checks++;
        if (parity !== 1'b1) begin errors++; $display("FAIL parity_0111 got %b required 1", parity); end
        load(4'b0110);
        checks++;
        if (parity !== 1'b0) begin errors++; $display("FAIL parity_0110 got %b required 0", parity); end
        load(4'b1011);
        checks++;
        if (parity !== 1'b1) begin errors++; $display("FAIL parity_1011 got %b required 1", parity); end
`else
        load(4'b0111);
        checks++;
        if (parity !== 1'b0) begin errors++; $display("FAIL parity_off_0111 got %b required 0", parity); end
        load(4'b0001);
        checks++;
        if (parity !== 1'b0) begin errors++; $display("FAIL parity_off_0001 got %b required 0", parity); end
`endif
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        data_in = '0;
        test_reset;
        test_load_sweep;
        test_wrap;
        test_hold_between_edges;
        test_mid_run_reset;
        test_parity;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
